// File: rtl/traffic_monitor.sv
// traffic_monitor: watches a four-way light controller for conflicts, bad codes, phase order and run timing.
// Run-length checking is built only when TRAFFIC_MON_TIMING_CHECK_EN is defined.
module traffic_monitor #(
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_light,
    input  logic [2:0] s_light,
    input  logic [2:0] e_light,
    input  logic [2:0] w_light,
    output logic [1:0] active_dir,
    output logic       locked,
    output logic       err_conflict,
    output logic       err_encoding,
    output logic       err_order,
    output logic       err_timing,
    output logic       err_any,
    output logic [7:0] rotations
);
    typedef enum logic [1:0] {HUNT, GREEN, YELLOW} state_t;
    state_t state, state_n;
    logic [3:0][2:0] lt;
    logic [3:0] nonred, grn, yel, bad;
    logic [1:0] idx, nxt, dir_n;
    logic conflict, encoding, single, fault, same_g, same_y, next_g, order_n, timing_n, rot_inc;

    if (GREEN_CYCLES < 1 || GREEN_CYCLES > 255 || YELLOW_CYCLES < 1 || YELLOW_CYCLES > 255) begin : g_bad_cycles
        $error("traffic_monitor: run lengths must be within 1..255");
    end

    assign lt = {w_light, e_light, s_light, n_light};
    for (genvar i = 0; i < 4; i++) begin : g_dec
        assign nonred[i] = lt[i] != 3'b000;
        assign grn[i]    = lt[i] == 3'b001;
        assign yel[i]    = lt[i] == 3'b010;
        assign bad[i]    = lt[i] > 3'b010;
    end

    assign conflict = |(nonred & (nonred - 4'd1));
    assign encoding = |bad;
    assign single   = !conflict && |nonred;
    assign idx      = nonred[1] ? 2'd1 : nonred[2] ? 2'd2 : nonred[3] ? 2'd3 : 2'd0;
    assign nxt      = active_dir + 2'd1;
    assign same_g   = single && grn[active_dir];
    assign same_y   = single && yel[active_dir];
    assign next_g   = single && grn[nxt];
    assign fault    = state != HUNT && (conflict || encoding);

    // A conflict or bad code while locked drops lock without also reporting an order error.
    always_comb begin
        state_n = state;
        dir_n   = active_dir;
        order_n = 1'b0;
        rot_inc = 1'b0;
        if (fault)
            state_n = HUNT;
        else if (state == HUNT) begin
            state_n = single && grn[idx] ? GREEN : HUNT;
            dir_n   = single && grn[idx] ? idx : active_dir;
        end else if (state == GREEN) begin
            state_n = same_y ? YELLOW : same_g ? GREEN : HUNT;
            order_n = !same_y && !same_g;
        end else begin
            state_n = next_g ? GREEN : same_y ? YELLOW : HUNT;
            order_n = !next_g && !same_y;
            dir_n   = next_g ? nxt : active_dir;
            rot_inc = next_g && active_dir == 2'd3;
        end
    end

`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    logic [7:0] run_cnt, limit;
    logic flagged, cont, new_run;
    assign limit    = state == GREEN ? 8'(GREEN_CYCLES) : 8'(YELLOW_CYCLES);
    assign cont     = state != HUNT && state_n == state;
    assign new_run  = state_n != HUNT && state_n != state;
    // Overrun fires when the next increment would pass the limit; underrun only on a legal phase change.
    assign timing_n = !flagged && ((cont && run_cnt >= limit) || (state != HUNT && new_run && run_cnt < limit));

    always_ff @(posedge clk) begin
        if (rst_a) begin
            run_cnt    <= 8'd0;
            flagged    <= 1'b0;
            err_timing <= 1'b0;
        end else begin
            run_cnt    <= new_run ? 8'd1 : cont ? run_cnt + {7'd0, run_cnt != 8'hff} : 8'd0;
            flagged    <= cont && (flagged || timing_n);
            err_timing <= timing_n;
        end
    end
`else
    assign timing_n   = 1'b0;
    assign err_timing = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state        <= HUNT;
            active_dir   <= 2'd0;
            locked       <= 1'b0;
            err_conflict <= 1'b0;
            err_encoding <= 1'b0;
            err_order    <= 1'b0;
            err_any      <= 1'b0;
            rotations    <= 8'd0;
        end else begin
            state        <= state_n;
            active_dir   <= dir_n;
            locked       <= state_n != HUNT;
            err_conflict <= conflict;
            err_encoding <= encoding;
            err_order    <= order_n;
            err_any      <= err_any | conflict | encoding | order_n | timing_n;
            rotations    <= rotations + {7'd0, rot_inc};
        end
    end
endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: scoreboard bench for traffic_monitor; a behavioural model queues expected outputs per sample.
module tb_traffic_monitor;
    localparam int GC = 8;
    localparam int YC = 4;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    localparam bit TIM = 1'b1;
`else
    localparam bit TIM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic [2:0] n_light = '0, s_light = '0, e_light = '0, w_light = '0;
    logic [1:0] active_dir;
    logic locked, err_conflict, err_encoding, err_order, err_timing, err_any;
    logic [7:0] rotations;
    logic [15:0] obs;

    traffic_monitor #(.GREEN_CYCLES(GC), .YELLOW_CYCLES(YC)) dut (
        .clk(clk), .rst_a(rst_a),
        .n_light(n_light), .s_light(s_light), .e_light(e_light), .w_light(w_light),
        .active_dir(active_dir), .locked(locked),
        .err_conflict(err_conflict), .err_encoding(err_encoding), .err_order(err_order),
        .err_timing(err_timing), .err_any(err_any), .rotations(rotations)
    );

    always #5 clk = ~clk;
    assign obs = {active_dir, locked, err_conflict, err_encoding, err_order, err_timing, err_any, rotations};

    typedef struct packed {
        logic [1:0] dir;
        logic lock, conf, enc, ord, tim, any;
        logic [7:0] rot;
    } exp_t;

    exp_t sb[$];
    int passed = 0, total = 0;
    int ms = 0, mdir = 0, mcnt = 0, mrot = 0, rd = 0;
    bit mlock = 0, mflag = 0, many = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %04h expected %04h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: ms 0=hunt 1=green 2=yellow, counts kept as plain integers.
    task automatic model(input logic [3:0][2:0] l, input bit r, output exp_t x);
        int nr = 0, g = 0;
        bit bad = 0, c, en, o = 0, t = 0;
        for (int i = 0; i < 4; i++) begin
            if (l[i] != 3'd0) begin nr++; g = i; end
            if (l[i] > 3'd2) bad = 1;
        end
        c = nr > 1;
        en = bad;
        if (r) begin
            ms = 0; mdir = 0; mlock = 0; mcnt = 0; mflag = 0; many = 0; mrot = 0;
            x = '0;
            return;
        end
        if (ms != 0 && (c || en)) begin
            ms = 0; mlock = 0;
        end else if (ms == 0) begin
            if (nr == 1 && l[g] == 3'd1) begin ms = 1; mdir = g; mlock = 1; mcnt = 1; mflag = 0; end
        end else if (ms == 1) begin
            if (nr == 1 && g == mdir && l[g] == 3'd1) begin
                if (mcnt >= GC && !mflag) begin t = 1; mflag = 1; end
                if (mcnt < 255) mcnt++;
            end else if (nr == 1 && g == mdir && l[g] == 3'd2) begin
                if (mcnt < GC && !mflag) t = 1;
                ms = 2; mcnt = 1; mflag = 0;
            end else begin
                o = 1; ms = 0; mlock = 0;
            end
        end else begin
            if (nr == 1 && g == mdir && l[g] == 3'd2) begin
                if (mcnt >= YC && !mflag) begin t = 1; mflag = 1; end
                if (mcnt < 255) mcnt++;
            end else if (nr == 1 && g == (mdir + 1) % 4 && l[g] == 3'd1) begin
                if (mcnt < YC && !mflag) t = 1;
                if (mdir == 3) mrot = (mrot + 1) % 256;
                mdir = (mdir + 1) % 4; ms = 1; mcnt = 1; mflag = 0;
            end else begin
                o = 1; ms = 0; mlock = 0;
            end
        end
        if (!TIM) t = 0;
        many = many | c | en | o | t;
        x = '{dir: mdir[1:0], lock: mlock, conf: c, enc: en, ord: o, tim: t, any: many, rot: mrot[7:0]};
    endtask

    function automatic logic [3:0][2:0] lights(input int d, input logic [2:0] code);
        logic [3:0][2:0] v = '0;
        v[d] = code;
        return v;
    endfunction

    task automatic step(input logic [3:0][2:0] l, input bit r);
        exp_t x, y;
        @(negedge clk);
        {w_light, e_light, s_light, n_light} = l;
        rst_a = r;
        model(l, r, x);
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        chk("outputs", obs, y);
    endtask

    task automatic phase(input int d, input int g, input int y);
        repeat (g) step(lights(d, 3'd1), 1'b0);
        repeat (y) step(lights(d, 3'd2), 1'b0);
    endtask

    initial begin
        repeat (2) step('0, 1'b1);
        chk("reset_outputs", obs, 16'd0);
        repeat (2) step('0, 1'b0);
        step(lights(1, 3'd2), 1'b0);
        chk("hunt_ignores_yellow", 16'(err_any), 16'd0);
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 4; d++) phase(d, GC, YC);
        step(lights(0, 3'd1), 1'b0);
        chk("rotations", 16'(rotations), 16'd2);
        chk("locked", 16'(locked), 16'd1);
        chk("clean_cycle", 16'(err_any), 16'd0);
        repeat (7) step(lights(0, 3'd1), 1'b0);
        chk("green_exact_len", 16'(err_timing), 16'd0);
        step(lights(0, 3'd1), 1'b0);
        chk("green_overrun", 16'(err_timing), 16'(TIM));
        repeat (YC) step(lights(0, 3'd2), 1'b0);
        chk("timing_sticky", 16'(err_any), 16'(TIM));
        step(lights(2, 3'd1), 1'b0);
        chk("order_pulse", 16'(err_order), 16'd1);
        chk("order_unlock", 16'(locked), 16'd0);
        phase(2, GC, YC);
        phase(3, GC, YC);
        repeat (3) step(lights(0, 3'd1), 1'b0);
        step(lights(0, 3'd1) | lights(2, 3'd1), 1'b0);
        chk("conflict", 16'(err_conflict), 16'd1);
        chk("conflict_order", 16'(err_order), 16'd0);
        chk("conflict_unlock", 16'(locked), 16'd0);
        step(lights(1, 3'b111), 1'b0);
        chk("encoding", 16'(err_encoding), 16'd1);
        repeat (3) step('0, 1'b0);
        chk("any_sticky", 16'(err_any), 16'd1);
        phase(0, GC, YC - 1);
        step(lights(1, 3'd1), 1'b0);
        chk("yellow_underrun", 16'(err_timing), 16'(TIM));
        phase(1, GC - 1, YC);
        phase(2, GC, YC);
        step('0, 1'b1);
        repeat (5) step(lights(1, 3'd1), 1'b0);
        step(lights(1, 3'd1), 1'b1);
        chk("reset_mid_run", obs, 16'd0);
        step(lights(1, 3'd1), 1'b0);
        chk("relock", 16'(locked), 16'd1);
        chk("relock_dir", 16'(active_dir), 16'd1);
        rd = 1;
        for (int k = 0; k < 40; k++) begin
            rd = (rd + ($urandom_range(0, 9) == 0 ? 2 : 1)) % 4;
            phase(rd, int'($urandom_range(GC - 2, GC + 2)), int'($urandom_range(YC - 2, YC + 2)));
            if ($urandom_range(0, 7) == 0) step(12'($urandom), 1'b0);
            if ($urandom_range(0, 19) == 0) step('0, 1'b1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
